// File: rtl/multichannel_rd_arbiter.sv
// Four-channel round-robin read arbiter in front of a single AXI read master.
// Launches the granted channel's burst, steers returned beats back to it and flags beat-count errors.
module multichannel_rd_arbiter #(
  parameter int AXI_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           rd_req,
  input  logic [29:0]          rd_addr0,
  input  logic [29:0]          rd_addr1,
  input  logic [29:0]          rd_addr2,
  input  logic [29:0]          rd_addr3,
  input  logic [7:0]           rd_len0,
  input  logic [7:0]           rd_len1,
  input  logic [7:0]           rd_len2,
  input  logic [7:0]           rd_len3,
  output logic [3:0]           rd_grant,
  output logic                 axi_rd_start,
  output logic [29:0]          axi_rd_addr,
  output logic [7:0]           axi_rd_len,
  input  logic [AXI_WIDTH-1:0] axi_rd_data,
  input  logic                 axi_rd_data_valid,
  input  logic                 rd_done,
  output logic [AXI_WIDTH-1:0] rd_data,
  output logic [3:0]           rd_data_valid,
  output logic                 rd_err,
  output logic [2:0]           dbg_state
);

  // Handshake: rd_req is a level request sampled only in IDLE; the grant is then held
  // until rd_done (or reset), and axi_rd_data_valid qualifies axi_rd_data per beat.

  typedef enum logic [2:0] {
    IDLE   = 3'b001,
    LAUNCH = 3'b010,
    BUSY   = 3'b100
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           last_ch_q, last_ch_d;
  logic [1:0]           ch_q, ch_d;
  logic [3:0]           grant_q, grant_d;
  logic [29:0]          addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [8:0]           beat_cnt_q, beat_cnt_d;
  logic [AXI_WIDTH-1:0] data_q;
  logic [3:0]           dvalid_q, dvalid_d;
  logic                 err_q, err_d;

  logic [1:0]           sel_ch;
  logic [1:0]           idx;
  logic [29:0]          sel_addr;
  logic [7:0]           sel_len;
  logic                 beat_in_len;
  logic [8:0]           beats_total;
  logic [8:0]           exp_beats;

  // Walk from furthest to nearest so the nearest requester after last_ch wins.
  always_comb begin
    sel_ch = last_ch_q;
    idx    = last_ch_q;
    for (int i = 4; i >= 1; i--) begin
      idx = last_ch_q + 2'(i);
      if (rd_req[idx]) sel_ch = idx;
    end
  end

  always_comb begin
    sel_addr = rd_addr0;
    sel_len  = rd_len0;
    case (sel_ch)
      2'd1: begin sel_addr = rd_addr1; sel_len = rd_len1; end
      2'd2: begin sel_addr = rd_addr2; sel_len = rd_len2; end
      2'd3: begin sel_addr = rd_addr3; sel_len = rd_len3; end
      default: begin sel_addr = rd_addr0; sel_len = rd_len0; end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_ch_d   = last_ch_q;
    ch_d        = ch_q;
    grant_d     = grant_q;
    addr_d      = addr_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    beat_in_len = beat_cnt_q <= {1'b0, len_q};
    exp_beats   = {1'b0, len_q} + 9'd1;
    beats_total = beat_cnt_q + {8'd0, axi_rd_data_valid};
    dvalid_d    = grant_q & {4{axi_rd_data_valid && beat_in_len}};

    case (state_q)
      IDLE: begin
        if (axi_rd_data_valid) err_d = 1'b1;
        if (rd_req != 4'b0000) begin
          ch_d       = sel_ch;
          grant_d    = 4'b0001 << sel_ch;
          addr_d     = sel_addr;
          len_d      = sel_len;
          beat_cnt_d = 9'd0;
          state_d    = LAUNCH;
        end
      end
      LAUNCH, BUSY: begin
        state_d = BUSY;
        if (axi_rd_data_valid) begin
          // Saturate so a runaway master cannot wrap the count back into range.
          if (beat_cnt_q != 9'h1ff) beat_cnt_d = beat_cnt_q + 9'd1;
          if (!beat_in_len) err_d = 1'b1;
        end
        if (rd_done) begin
          if (beats_total != exp_beats) err_d = 1'b1;
          last_ch_d = ch_q;
          grant_d   = 4'b0000;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_ch_q  <= 2'd3;
      ch_q       <= 2'd0;
      grant_q    <= 4'b0000;
      addr_q     <= 30'd0;
      len_q      <= 8'd0;
      beat_cnt_q <= 9'd0;
      data_q     <= '0;
      dvalid_q   <= 4'b0000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_ch_q  <= last_ch_d;
      ch_q       <= ch_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      data_q     <= axi_rd_data;
      dvalid_q   <= dvalid_d;
      err_q      <= err_d;
    end
  end

  assign rd_grant      = grant_q;
  assign axi_rd_start  = (state_q == LAUNCH);
  assign axi_rd_addr   = addr_q;
  assign axi_rd_len    = len_q;
  assign rd_data       = data_q;
  assign rd_data_valid = dvalid_q;
  assign rd_err        = err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_multichannel_rd_arbiter.sv
// Self-checking bench for multichannel_rd_arbiter: grant order, launch pulse, beat steering,
// beat-count errors, grant hold and reset behaviour, with a beat scoreboard.
module tb_multichannel_rd_arbiter;
  localparam int W = 64;

  logic          clk;
  logic          rst_n;
  logic [3:0]    rd_req;
  logic [29:0]   addr [4];
  logic [7:0]    len [4];
  logic [3:0]    rd_grant;
  logic          axi_rd_start;
  logic [29:0]   axi_rd_addr;
  logic [7:0]    axi_rd_len;
  logic [W-1:0]  axi_rd_data;
  logic          axi_rd_data_valid;
  logic          rd_done;
  logic [W-1:0]  rd_data;
  logic [3:0]    rd_data_valid;
  logic          rd_err;
  logic [2:0]    dbg_state;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  logic          exp_err = 1'b0;
  logic [W+3:0]  exp_q [$];
  int            cyc_q [$];

  multichannel_rd_arbiter #(.AXI_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req),
    .rd_addr0(addr[0]), .rd_addr1(addr[1]), .rd_addr2(addr[2]), .rd_addr3(addr[3]),
    .rd_len0(len[0]), .rd_len1(len[1]), .rd_len2(len[2]), .rd_len3(len[3]),
    .rd_grant(rd_grant), .axi_rd_start(axi_rd_start),
    .axi_rd_addr(axi_rd_addr), .axi_rd_len(axi_rd_len),
    .axi_rd_data(axi_rd_data), .axi_rd_data_valid(axi_rd_data_valid), .rd_done(rd_done),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_err(rd_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W+3:0] got, input logic [W+3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every steered output beat must match the next expected beat and cycle.
  always @(negedge clk) begin
    if (rst_n && rd_data_valid != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {60'd0, rd_data_valid}, 64'd0);
      end else begin
        check("beat", {rd_data_valid, rd_data}, exp_q.pop_front());
        check("beat_cycle", cyc, cyc_q.pop_front());
      end
    end
  end

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (axi_rd_start) seen = 1'b1;
    end
    check("start_seen", {67'd0, seen}, 68'd1);
  endtask

  task automatic drive_beat(input int ch, input bit steered, input bit done);
    axi_rd_data_valid = 1'b1;
    axi_rd_data       = {$urandom, $urandom};
    rd_done           = done;
    if (steered) begin
      exp_q.push_back({4'b0001 << ch, axi_rd_data});
      cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic run_burst(input int ch, input int nbeats, input bit done_with_last,
                           input logic [3:0] new_req);
    bit seen;
    wait_start(seen);
    if (!seen) return;
    check("grant", {64'd0, rd_grant}, {64'd0, 4'b0001 << ch});
    check("axi_addr", {38'd0, axi_rd_addr}, {38'd0, addr[ch]});
    check("axi_len", {60'd0, axi_rd_len}, {60'd0, len[ch]});
    if (nbeats != int'(len[ch]) + 1) exp_err = 1'b1;
    for (int k = 0; k < nbeats; k++) begin
      @(posedge clk); #1;
      rd_req = new_req;
      drive_beat(ch, k <= int'(len[ch]), done_with_last && (k == nbeats - 1));
      @(negedge clk);
      check("start_pulse", {67'd0, axi_rd_start}, 68'd0);
      check("grant_hold", {64'd0, rd_grant}, {64'd0, 4'b0001 << ch});
    end
    if (!done_with_last) begin
      @(posedge clk); #1;
      axi_rd_data_valid = 1'b0;
      rd_done = 1'b1;
    end
    @(posedge clk); #1;
    axi_rd_data_valid = 1'b0;
    rd_done = 1'b0;
    @(negedge clk);
    check("grant_clr", {64'd0, rd_grant}, 68'd0);
    check("idle_start", {67'd0, axi_rd_start}, 68'd0);
    check("rd_err", {67'd0, rd_err}, {67'd0, exp_err});
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    rd_req = 4'b0000;
    axi_rd_data = '0;
    axi_rd_data_valid = 1'b0;
    rd_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = 30'($urandom_range(0, 32'h3fff_ffff));
      len[i]  = 8'd3;
    end
    repeat (3) @(negedge clk);
    check("rst_grant", {64'd0, rd_grant}, 68'd0);
    check("rst_start", {67'd0, axi_rd_start}, 68'd0);
    check("rst_valid", {64'd0, rd_data_valid}, 68'd0);
    check("rst_err", {67'd0, rd_err}, 68'd0);
    check("rst_addr", {38'd0, axi_rd_addr}, 68'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Round-robin with all channels requesting, rd_done with the last beat on odd bursts.
    rd_req = 4'b1111;
    run_burst(0, 4, 1'b0, 4'b1111);
    run_burst(1, 4, 1'b1, 4'b1111);
    run_burst(2, 4, 1'b0, 4'b1111);
    run_burst(3, 4, 1'b1, 4'b1111);
    run_burst(0, 4, 1'b0, 4'b0000);

    // Single requester, steering to ch2 only.
    addr[2] = 30'h100;
    len[2]  = 8'd7;
    rd_req  = 4'b0100;
    run_burst(2, 8, 1'b0, 4'b0000);

    // Grant hold: ch0 drops request mid-burst, ch3 raises; ch3 follows.
    rd_req = 4'b0001;
    run_burst(0, 4, 1'b0, 4'b1000);
    len[3] = 8'd255;
    run_burst(3, 256, 1'b1, 4'b1111);

    // Search restarts at ch0 after a ch3 burst.
    run_burst(0, 4, 1'b0, 4'b0010);

    // Overrun on ch1 (len=1, three beats): sticky rd_err.
    len[1] = 8'd1;
    run_burst(1, 3, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    check("err_sticky", {67'd0, rd_err}, 68'd1);

    // Reset in the middle of a ch1 burst.
    len[1] = 8'd3;
    rd_req = 4'b0010;
    wait_start(seen);
    @(posedge clk); #1;
    drive_beat(1, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive_beat(1, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_valid", {64'd0, rd_data_valid}, {64'd0, 4'b0010});
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", {64'd0, rd_grant}, 68'd0);
    check("mid_rst_start", {67'd0, axi_rd_start}, 68'd0);
    check("mid_rst_valid", {64'd0, rd_data_valid}, 68'd0);
    axi_rd_data_valid = 1'b0;
    rd_req = 4'b1000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_err = 1'b0;
    check("post_rst_err", {67'd0, rd_err}, 68'd0);
    len[3] = 8'd2;
    run_burst(3, 3, 1'b1, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 68'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
